// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the LC-3 memory sequencer.
// Holds the FSM state enum and the per-state SRAM strobe encoding.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACT,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_IO_ACK
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic d_oe;
    } strobe_t;

    // {CE_N, OE_N, WE_N, D_Oe} driven while sitting in each state
    localparam strobe_t STRB_IDLE  = 4'b1110;
    localparam strobe_t STRB_RD    = 4'b0010;
    localparam strobe_t STRB_SETUP = 4'b0111;
    localparam strobe_t STRB_PULSE = 4'b0101;
    localparam strobe_t STRB_HOLD  = 4'b0111;
    localparam strobe_t STRB_IO    = 4'b1110;

    function automatic strobe_t strobe_of(input mem_state_t s);
        strobe_t r;
        case (s)
            S_RD_ACT:   r = STRB_RD;
            S_WR_SETUP: r = STRB_SETUP;
            S_WR_PULSE: r = STRB_PULSE;
            S_WR_HOLD:  r = STRB_HOLD;
            S_IO_ACK:   r = STRB_IO;
            default:    r = STRB_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Request, I/O and SRAM bus bundle of the memory sequencer.
// slave is the sequencer side, master the control unit / board side.
interface mem_sequencer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              Req_Rd;
    logic              Req_Wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic [DATA_W-1:0] Rd_Data;
    logic              Done;
    logic              Busy;
    logic              Req_Err;
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] Hex_Out;
    logic [ADDR_W-1:0] Sram_Addr;
    logic              Sram_CE_N;
    logic              Sram_OE_N;
    logic              Sram_WE_N;
    logic              Sram_UB_N;
    logic              Sram_LB_N;
    logic [DATA_W-1:0] Sram_D_Out;
    logic              Sram_D_Oe;
    logic [DATA_W-1:0] Sram_D_In;

    modport slave (
        input  Req_Rd, Req_Wr, Addr, Wr_Data, Switches, Sram_D_In,
        output Rd_Data, Done, Busy, Req_Err, Hex_Out,
        output Sram_Addr, Sram_CE_N, Sram_OE_N, Sram_WE_N,
        output Sram_UB_N, Sram_LB_N, Sram_D_Out, Sram_D_Oe
    );

    modport master (
        output Req_Rd, Req_Wr, Addr, Wr_Data, Switches, Sram_D_In,
        input  Rd_Data, Done, Busy, Req_Err, Hex_Out,
        input  Sram_Addr, Sram_CE_N, Sram_OE_N, Sram_WE_N,
        input  Sram_UB_N, Sram_LB_N, Sram_D_Out, Sram_D_Oe
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: load has priority, decrement stops at zero.
// zero flags the last cycle of a timed strobe phase.
module mem_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load on phase entry, count down otherwise, never wrap below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_sequencer.sv
// LC-3 memory sequencer: timed SRAM reads/writes with wait states,
// plus the switch / hex-display I/O location.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int          ADDR_W  = 20,
    parameter int          DATA_W  = 16,
    parameter int          RD_WAIT = 2,
    parameter int          WR_WAIT = 2,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEF
) (
    input logic            Clk,
    input logic            Reset,
    mem_sequencer_if.slave bus
);

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    mem_state_t        state;
    strobe_t           strb;
    logic              bl_n;
    logic              is_wr;
    logic              done;
    logic              req_err;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] d_out;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] hex;

    logic       req;
    logic       io_hit;
    logic       cnt_load;
    logic [3:0] cnt_val;
    logic       cnt_dec;
    logic       cnt_zero;

    assign req    = bus.Req_Rd | bus.Req_Wr;
    assign io_hit = (bus.Addr[15:0] == IO_ADDR);

    // counter is loaded when entering RD_ACT or WR_PULSE
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = RD_LOAD;
        cnt_dec  = 1'b0;
        if (state == S_IDLE && req && !io_hit && !bus.Req_Wr) begin
            cnt_load = 1'b1;
        end
        if (state == S_WR_SETUP) begin
            cnt_load = 1'b1;
            cnt_val  = WR_LOAD;
        end
        if (state == S_RD_ACT || state == S_WR_PULSE) begin
            cnt_dec = 1'b1;
        end
    end

    mem_wait_counter #(.W(4)) u_wait (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // sequencer FSM; strobes registered from the state being entered
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            strb      <= STRB_IDLE;
            bl_n      <= 1'b1;
            is_wr     <= 1'b0;
            done      <= 1'b0;
            req_err   <= 1'b0;
            sram_addr <= '0;
            d_out     <= '0;
            rd_data   <= '0;
            hex       <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && req) begin
                req_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        is_wr <= bus.Req_Wr;
                        if (io_hit) begin
                            state <= S_IO_ACK;
                            strb  <= strobe_of(S_IO_ACK);
                            bl_n  <= 1'b1;
                        end else begin
                            sram_addr <= bus.Addr;
                            d_out     <= bus.Wr_Data;
                            bl_n      <= 1'b0;
                            if (bus.Req_Wr) begin
                                state <= S_WR_SETUP;
                                strb  <= strobe_of(S_WR_SETUP);
                            end else begin
                                state <= S_RD_ACT;
                                strb  <= strobe_of(S_RD_ACT);
                            end
                        end
                    end
                end
                S_RD_ACT: begin
                    if (cnt_zero) begin
                        rd_data <= bus.Sram_D_In;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                        strb    <= strobe_of(S_IDLE);
                        bl_n    <= 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    state <= S_WR_PULSE;
                    strb  <= strobe_of(S_WR_PULSE);
                end
                S_WR_PULSE: begin
                    if (cnt_zero) begin
                        state <= S_WR_HOLD;
                        strb  <= strobe_of(S_WR_HOLD);
                    end
                end
                S_WR_HOLD: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    strb  <= strobe_of(S_IDLE);
                    bl_n  <= 1'b1;
                end
                S_IO_ACK: begin
                    if (is_wr) begin
                        hex <= bus.Wr_Data;
                    end else begin
                        rd_data <= bus.Switches;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                    strb  <= strobe_of(S_IDLE);
                    bl_n  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    strb  <= strobe_of(S_IDLE);
                    bl_n  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Rd_Data    = rd_data;
    assign bus.Done       = done;
    assign bus.Busy       = (state != S_IDLE);
    assign bus.Req_Err    = req_err;
    assign bus.Hex_Out    = hex;
    assign bus.Sram_Addr  = sram_addr;
    assign bus.Sram_CE_N  = strb.ce_n;
    assign bus.Sram_OE_N  = strb.oe_n;
    assign bus.Sram_WE_N  = strb.we_n;
    assign bus.Sram_UB_N  = bl_n;
    assign bus.Sram_LB_N  = bl_n;
    assign bus.Sram_D_Out = d_out;
    assign bus.Sram_D_Oe  = strb.d_oe;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer.
// Cycle n is observed 1ns after the n-th rising edge following a request.
module tb_mem_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_sequencer_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    mem_sequencer #(
        .ADDR_W  (20),
        .DATA_W  (16),
        .RD_WAIT (2),
        .WR_WAIT (2),
        .IO_ADDR (16'hFFFF)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_overlap(input string tag);
        check(tag, {31'd0, bus.Sram_D_Oe & ~bus.Sram_OE_N}, 32'd0);
    endtask

    // expected write waveform, cycles 1..5
    logic [4:0] wr_we;
    logic [4:0] wr_oe;
    logic [4:0] wr_done;
    logic [4:0] wr_ce;

    initial begin
        checks   = 0;
        failures = 0;
        wr_we    = 5'b10011;
        wr_oe    = 5'b11110;
        wr_done  = 5'b00001;
        wr_ce    = 5'b00001;

        rst_n        = 1'b0;
        bus.Req_Rd   = 1'b0;
        bus.Req_Wr   = 1'b0;
        bus.Addr     = '0;
        bus.Wr_Data  = '0;
        bus.Switches = '0;
        bus.Sram_D_In = '0;
        repeat (3) tick();

        check("rst_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("rst_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        check("rst_we", {31'd0, bus.Sram_WE_N}, 32'd1);
        check("rst_ublb", {30'd0, bus.Sram_UB_N, bus.Sram_LB_N}, 32'd3);
        check("rst_doe", {31'd0, bus.Sram_D_Oe}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_err", {31'd0, bus.Req_Err}, 32'd0);
        check("rst_rd", {16'd0, bus.Rd_Data}, 32'd0);
        check("rst_hex", {16'd0, bus.Hex_Out}, 32'd0);
        check("rst_addr", {12'd0, bus.Sram_Addr}, 32'd0);

        rst_n = 1'b1;
        tick();

        // SRAM read
        bus.Req_Rd    = 1'b1;
        bus.Addr      = 20'h00123;
        bus.Sram_D_In = 16'hBEEF;
        tick();
        bus.Req_Rd = 1'b0;
        check("rd_c1_ce", {31'd0, bus.Sram_CE_N}, 32'd0);
        check("rd_c1_oe", {31'd0, bus.Sram_OE_N}, 32'd0);
        check("rd_c1_ub", {31'd0, bus.Sram_UB_N}, 32'd0);
        check("rd_c1_busy", {31'd0, bus.Busy}, 32'd1);
        check("rd_c1_addr", {12'd0, bus.Sram_Addr}, 32'h00123);
        no_overlap("rd_c1_ovl");
        tick();
        check("rd_c2_oe", {31'd0, bus.Sram_OE_N}, 32'd0);
        check("rd_c2_done", {31'd0, bus.Done}, 32'd0);
        tick();
        check("rd_c3_done", {31'd0, bus.Done}, 32'd1);
        check("rd_c3_data", {16'd0, bus.Rd_Data}, 32'hBEEF);
        check("rd_c3_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        check("rd_c3_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("rd_c3_busy", {31'd0, bus.Busy}, 32'd0);
        tick();
        check("rd_c4_done", {31'd0, bus.Done}, 32'd0);

        // SRAM write
        bus.Req_Wr  = 1'b1;
        bus.Addr    = 20'h00040;
        bus.Wr_Data = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.Req_Wr  = 1'b0;
            bus.Addr    = 20'h0ABCD;
            bus.Wr_Data = 16'hDEAD;
            check($sformatf("wr_c%0d_we", c),
                  {31'd0, bus.Sram_WE_N}, {31'd0, wr_we[5-c]});
            check($sformatf("wr_c%0d_doe", c),
                  {31'd0, bus.Sram_D_Oe}, {31'd0, wr_oe[5-c]});
            check($sformatf("wr_c%0d_done", c),
                  {31'd0, bus.Done}, {31'd0, wr_done[5-c]});
            check($sformatf("wr_c%0d_ce", c),
                  {31'd0, bus.Sram_CE_N}, {31'd0, wr_ce[5-c]});
            check($sformatf("wr_c%0d_oe", c), {31'd0, bus.Sram_OE_N}, 32'd1);
            if (c == 2) begin
                check("wr_dout", {16'd0, bus.Sram_D_Out}, 32'h1234);
                check("wr_addr", {12'd0, bus.Sram_Addr}, 32'h00040);
            end
        end
        check("wr_rd_keep", {16'd0, bus.Rd_Data}, 32'hBEEF);
        tick();

        // I/O write to the hex display
        bus.Req_Wr  = 1'b1;
        bus.Addr    = 20'h0FFFF;
        bus.Wr_Data = 16'h00A5;
        tick();
        bus.Req_Wr = 1'b0;
        check("iow_c1_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("iow_c1_busy", {31'd0, bus.Busy}, 32'd1);
        check("iow_c1_done", {31'd0, bus.Done}, 32'd0);
        tick();
        check("iow_c2_done", {31'd0, bus.Done}, 32'd1);
        check("iow_c2_hex", {16'd0, bus.Hex_Out}, 32'h00A5);
        check("iow_c2_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("iow_rd_keep", {16'd0, bus.Rd_Data}, 32'hBEEF);
        tick();

        // I/O read of the switches
        bus.Req_Rd   = 1'b1;
        bus.Switches = 16'h0F0F;
        tick();
        bus.Req_Rd = 1'b0;
        check("ior_c1_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("ior_c1_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        tick();
        check("ior_c2_done", {31'd0, bus.Done}, 32'd1);
        check("ior_c2_data", {16'd0, bus.Rd_Data}, 32'h0F0F);
        check("ior_hex_keep", {16'd0, bus.Hex_Out}, 32'h00A5);
        check("ior_err", {31'd0, bus.Req_Err}, 32'd0);
        tick();

        // both requests: write wins; read during WR_PULSE is dropped
        bus.Req_Rd  = 1'b1;
        bus.Req_Wr  = 1'b1;
        bus.Addr    = 20'h00200;
        bus.Wr_Data = 16'h5555;
        tick();
        bus.Req_Rd = 1'b0;
        bus.Req_Wr = 1'b0;
        check("pri_c1_doe", {31'd0, bus.Sram_D_Oe}, 32'd1);
        check("pri_c1_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        tick();
        check("pri_c2_we", {31'd0, bus.Sram_WE_N}, 32'd0);
        check("pri_c2_err", {31'd0, bus.Req_Err}, 32'd0);
        bus.Req_Rd = 1'b1;
        tick();
        bus.Req_Rd = 1'b0;
        check("pri_c3_err", {31'd0, bus.Req_Err}, 32'd1);
        check("pri_c3_we", {31'd0, bus.Sram_WE_N}, 32'd0);
        tick();
        tick();
        check("pri_c5_done", {31'd0, bus.Done}, 32'd1);
        check("pri_dout", {16'd0, bus.Sram_D_Out}, 32'h5555);
        tick();
        check("pri_c6_busy", {31'd0, bus.Busy}, 32'd0);
        check("pri_c6_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        check("pri_rd_keep", {16'd0, bus.Rd_Data}, 32'h0F0F);
        tick();

        // read accepted in the Done cycle of a write
        bus.Req_Wr  = 1'b1;
        bus.Addr    = 20'h00300;
        bus.Wr_Data = 16'hAAAA;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.Req_Wr = 1'b0;
            no_overlap($sformatf("b2b_w%0d_ovl", c));
        end
        check("b2b_w5_done", {31'd0, bus.Done}, 32'd1);
        bus.Req_Rd    = 1'b1;
        bus.Addr      = 20'h00301;
        bus.Sram_D_In = 16'h1357;
        tick();
        bus.Req_Rd = 1'b0;
        check("b2b_r1_oe", {31'd0, bus.Sram_OE_N}, 32'd0);
        check("b2b_r1_doe", {31'd0, bus.Sram_D_Oe}, 32'd0);
        check("b2b_r1_addr", {12'd0, bus.Sram_Addr}, 32'h00301);
        no_overlap("b2b_r1_ovl");
        tick();
        no_overlap("b2b_r2_ovl");
        tick();
        check("b2b_r3_done", {31'd0, bus.Done}, 32'd1);
        check("b2b_r3_data", {16'd0, bus.Rd_Data}, 32'h1357);
        tick();

        // asynchronous reset in the middle of RD_ACT
        bus.Req_Rd    = 1'b1;
        bus.Addr      = 20'h00777;
        bus.Sram_D_In = 16'h4242;
        tick();
        bus.Req_Rd = 1'b0;
        check("arst_pre_oe", {31'd0, bus.Sram_OE_N}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ce", {31'd0, bus.Sram_CE_N}, 32'd1);
        check("arst_oe", {31'd0, bus.Sram_OE_N}, 32'd1);
        check("arst_we", {31'd0, bus.Sram_WE_N}, 32'd1);
        check("arst_doe", {31'd0, bus.Sram_D_Oe}, 32'd0);
        check("arst_busy", {31'd0, bus.Busy}, 32'd0);
        check("arst_rd", {16'd0, bus.Rd_Data}, 32'd0);
        check("arst_hex", {16'd0, bus.Hex_Out}, 32'd0);
        check("arst_err", {31'd0, bus.Req_Err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_after_busy", {31'd0, bus.Busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Sits directly downstream of the LC-3 control unit, between the MAR/MDR datapath and the board SRAM plus memory-mapped I/O.
- Converts single-cycle read/write requests from the control unit into timed SRAM accesses with programmable wait states.
- Returns read data to the MDR with a completion pulse.
- Decodes the I/O address to the switch input and the hex-display register.

Parameters:
- ADDR_W, 20, SRAM address width; MAR is zero-extended to this width.
- DATA_W, 16, word width.
- RD_WAIT, 2, cycles OE_N is held low per SRAM read (legal range 1..15).
- WR_WAIT, 2, cycles WE_N is held low per SRAM write (legal range 1..15).
- IO_ADDR, 16'hFFFF, memory-mapped I/O address, compared against Addr[15:0].

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req_Rd  in  1  read request; sampled only in IDLE.
- Req_Wr  in  1  write request; sampled only in IDLE.
- Addr  in  ADDR_W  access address (from MAR).
- Wr_Data  in  DATA_W  write data (from MDR).
- Rd_Data  out  DATA_W  read data (to MDR mux).
- Done  out  1  one-cycle completion pulse, reads and writes.
- Busy  out  1  high whenever state != IDLE.
- Req_Err  out  1  sticky flag: a request arrived while Busy.
- Switches  in  DATA_W  board switches, read at IO_ADDR.
- Hex_Out  out  DATA_W  display register, written at IO_ADDR.
- Sram_Addr  out  ADDR_W  registered SRAM address.
- Sram_CE_N, Sram_OE_N, Sram_WE_N, Sram_UB_N, Sram_LB_N  out  1 each  active-low SRAM strobes.
- Sram_D_Out  out  DATA_W  data to drive onto the bus.
- Sram_D_Oe  out  1  tristate enable; the top level owns the tristate buffer.
- Sram_D_In  in  DATA_W  data sampled from the bus.

Behaviour:
- Reset (asynchronous, Reset=0): state=IDLE.
  - All SRAM strobes = 1; Sram_D_Oe=0.
  - Sram_Addr, Sram_D_Out, Rd_Data, Hex_Out = 0.
  - Done=0, Req_Err=0.
  - Reset mid-access aborts immediately and strobes deassert without waiting for a clock edge.
- Every strobe and Sram_D_Oe is a flop output; no combinational decode reaches the pins.
- UB_N/LB_N = 0 while CE_N=0; otherwise 1.
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, IO_ACK.
- IDLE:
  - Req_Wr has priority when Req_Wr and Req_Rd are both high.
  - Addr[15:0]==IO_ADDR goes to IO_ACK with no SRAM activity; otherwise Addr and Wr_Data are latched.
- IO_ACK (1 cycle):
  - Read: Rd_Data<=Switches.
  - Write: Hex_Out<=Wr_Data.
  - Done pulses in the following cycle.
- SRAM read (request in cycle 0):
  - Cycles 1..RD_WAIT: RD_ACT with CE_N=0, OE_N=0.
  - Edge ending cycle RD_WAIT captures Sram_D_In into Rd_Data.
  - Cycle RD_WAIT+1: Done=1, state IDLE, strobes high.
- SRAM write (request in cycle 0):
  - Cycle 1: WR_SETUP, CE_N=0, WE_N=1, Sram_D_Oe=1.
  - Cycles 2..WR_WAIT+1: WR_PULSE, WE_N=0.
  - Cycle WR_WAIT+2: WR_HOLD, WE_N=1, data still driven.
  - Cycle WR_WAIT+3: Done=1, IDLE, Sram_D_Oe=0.
- Data timing rules:
  - Sram_D_Oe is never 1 in the same cycle as OE_N=0.
  - Rd_Data holds its value between reads; writes never change it.
- Wait counter: 4-bit down-counter, loaded with WAIT-1 on state entry. Exit occurs when it reaches 0. No wrap.
- Busy=1 in every non-IDLE state.
- Req_Rd/Req_Wr seen while Busy: dropped and Req_Err<=1 (cleared only by reset).
- A request in the Done cycle (IDLE) is accepted normally, giving back-to-back operation.

Decomposition:
- Package mem_seq_pkg holds:
  - the state enum (mem_state_t);
  - the IO_ADDR default;
  - strobe-vector encoding constants for {CE_N,OE_N,WE_N,D_Oe} per state, used for the registered next-strobe lookup.
- Sub-module mem_wait_counter: load/decrement/zero flag, parameterised width. Instantiated once.

Test Plan:
- Reset low mid-RD_ACT -> strobes all 1 and Sram_D_Oe=0 before the next edge; Busy=0, Rd_Data=0.
- Req_Rd, Addr=20'h00123, Sram_D_In=16'hBEEF, RD_WAIT=2 -> OE_N low in cycles 1-2, Done and Rd_Data=16'hBEEF in cycle 3.
- Req_Wr, Addr=20'h00040, Wr_Data=16'h1234, WR_WAIT=2 -> WE_N low in cycles 2-3 only, D_Oe high in cycles 1-4, Done in cycle 5; Rd_Data unchanged.
- Write Addr=16'hFFFF, Wr_Data=16'h00A5 -> Hex_Out=16'h00A5, Done in cycle 2, CE_N stays 1; a read of IO_ADDR with Switches=16'h0F0F returns 16'h0F0F.
- Req_Rd and Req_Wr asserted together -> write sequence executes; a Req_Rd pulse during WR_PULSE sets Req_Err=1 and is not executed.
- Read issued in a Done cycle immediately after a write -> accepted with no idle gap, and D_Oe and OE_N never overlap.
